// File: rtl/timer_bank_pkg.sv
// Shared defaults, channel mode enum and prescaler divisor helper for timer_bank.
package timer_bank_pkg;

  localparam int DEF_CLK_FREQ_HZ = 1000000;
  localparam int DEF_TICK_HZ     = 1000;
  localparam int DEF_N_CH        = 4;
  localparam int DEF_CNT_W       = 32;

  typedef enum logic {
    ONE_SHOT = 1'b0,
    PERIODIC = 1'b1
  } mode_e;

  // Falls back to 1 on illegal frequency pairs so elaboration can still report the error.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    if (tick_hz <= 0 || clk_hz < tick_hz) return 1;
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One alarm channel: deadline/interval bookkeeping, sticky irq and optional timestamp capture.
// Capture logic is present only when TIMER_BANK_CAPTURE_EN is defined.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             tick,
  input  logic [CNT_W-1:0] timestamp,
  input  logic             wr,
  input  logic [CNT_W-1:0] cfg_interval,
  input  logic             cfg_periodic,
  input  logic             cfg_arm,
  input  logic             irq_clr,
  output logic             irq,
  output logic             armed
`ifdef TIMER_BANK_CAPTURE_EN
  ,
  input  logic             cap_in,
  output logic             cap_valid,
  output logic [CNT_W-1:0] cap_value
`endif
);

  logic [CNT_W-1:0] interval;
  logic [CNT_W-1:0] deadline;
  mode_e            mode;
  logic             match;

  // A configuration write in the same cycle overrides any pending match.
  assign match = tick && enable && armed && (timestamp == deadline) && !wr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      interval <= '0;
      deadline <= '0;
      mode     <= ONE_SHOT;
      armed    <= 1'b0;
    end else if (wr) begin
      interval <= cfg_interval;
      mode     <= cfg_periodic ? PERIODIC : ONE_SHOT;
      deadline <= timestamp + cfg_interval;
      armed    <= cfg_arm && (cfg_interval != '0);
    end else if (match) begin
      if (mode == PERIODIC) begin
        deadline <= deadline + interval;
      end else begin
        armed <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq <= 1'b0;
    end else if (match) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end

`ifdef TIMER_BANK_CAPTURE_EN
  // Two synchroniser flops plus a delayed copy for rising-edge detection.
  logic [2:0] cap_sync;
  logic       cap_rise;

  assign cap_rise = cap_sync[1] && !cap_sync[2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_sync  <= '0;
      cap_valid <= 1'b0;
      cap_value <= '0;
    end else begin
      cap_sync <= {cap_sync[1:0], cap_in};
      if (cap_rise) begin
        cap_valid <= 1'b1;
        cap_value <= timestamp;
      end else if (irq_clr) begin
        cap_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: rtl/timer_bank.sv
// Prescaled timestamp counter with N_CH alarm channels (one-shot or periodic).
// Define TIMER_BANK_CAPTURE_EN to add per-channel input-capture ports.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int TICK_HZ     = DEF_TICK_HZ,
  parameter int N_CH        = DEF_N_CH,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    enable,
  input  logic                                    clear,
  output logic [CNT_W-1:0]                        timestamp,
  output logic                                    tick,
  input  logic                                    cfg_we,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                        cfg_interval,
  input  logic                                    cfg_periodic,
  input  logic                                    cfg_arm,
  output logic [N_CH-1:0]                         irq,
  input  logic [N_CH-1:0]                         irq_clr,
  output logic [N_CH-1:0]                         armed
`ifdef TIMER_BANK_CAPTURE_EN
  ,
  input  logic [N_CH-1:0]                         cap_in,
  output logic [N_CH-1:0]                         cap_valid,
  output logic [N_CH*CNT_W-1:0]                   cap_value
`endif
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int DIV  = calc_div(CLK_FREQ_HZ, TICK_HZ);
  localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

  if (TICK_HZ <= 0 || TICK_HZ > CLK_FREQ_HZ ||
      (CLK_FREQ_HZ % ((TICK_HZ > 0) ? TICK_HZ : 1)) != 0) begin : g_bad_freq
    $error("timer_bank: CLK_FREQ_HZ must be a positive multiple of TICK_HZ");
  end

  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $error("timer_bank: N_CH must be within 1..16");
  end

  logic [PS_W-1:0] prescaler;

  // With DIV=1 the prescaler stays at 0 and every enabled cycle is a tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
      timestamp <= '0;
      tick      <= 1'b0;
    end else if (clear) begin
      prescaler <= '0;
      timestamp <= '0;
      tick      <= 1'b0;
    end else if (enable) begin
      if (prescaler == PS_LAST) begin
        prescaler <= '0;
        timestamp <= timestamp + CNT_W'(1);
        tick      <= 1'b1;
      end else begin
        prescaler <= prescaler + PS_W'(1);
        tick      <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    timer_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .tick         (tick),
      .timestamp    (timestamp),
      .wr           (cfg_we && (cfg_ch == CH_W'(i))),
      .cfg_interval (cfg_interval),
      .cfg_periodic (cfg_periodic),
      .cfg_arm      (cfg_arm),
      .irq_clr      (irq_clr[i]),
      .irq          (irq[i]),
      .armed        (armed[i])
`ifdef TIMER_BANK_CAPTURE_EN
      ,
      .cap_in       (cap_in[i]),
      .cap_valid    (cap_valid[i]),
      .cap_value    (cap_value[i*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_timer_bank.sv
// Randomized and directed checks of timer_bank against a behavioural model of the timer rules.
// Capture checks run only when TIMER_BANK_CAPTURE_EN is defined.
module tb_timer_bank;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: default 1 MHz / 1 kHz timebase, used only for the prescaler check.
  logic        en_a;
  logic [31:0] ts_a;
  logic        tick_a;
  logic [3:0]  irq_a, armed_a;
`ifdef TIMER_BANK_CAPTURE_EN
  logic [3:0]   cap_valid_a;
  logic [127:0] cap_value_a;
`endif

  timer_bank dut_a (
    .clk(clk), .reset(reset), .enable(en_a), .clear(1'b0),
    .timestamp(ts_a), .tick(tick_a),
    .cfg_we(1'b0), .cfg_ch(2'd0), .cfg_interval(32'd0), .cfg_periodic(1'b0), .cfg_arm(1'b0),
    .irq(irq_a), .irq_clr(4'd0), .armed(armed_a)
`ifdef TIMER_BANK_CAPTURE_EN
    , .cap_in(4'd0), .cap_valid(cap_valid_a), .cap_value(cap_value_a)
`endif
  );

  // Instance W: DIV=4, 8-bit timestamps so wrap-around is reachable quickly.
  logic       enable, clear, cfg_we, cfg_periodic, cfg_arm;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_interval, ts;
  logic       tick;
  logic [3:0] irq, irq_clr, armed;
`ifdef TIMER_BANK_CAPTURE_EN
  logic [3:0]  cap_in, cap_valid;
  logic [31:0] cap_value;
`endif

  timer_bank #(.CLK_FREQ_HZ(4), .TICK_HZ(1), .N_CH(4), .CNT_W(8)) dut_w (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .timestamp(ts), .tick(tick),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_interval(cfg_interval),
    .cfg_periodic(cfg_periodic), .cfg_arm(cfg_arm),
    .irq(irq), .irq_clr(irq_clr), .armed(armed)
`ifdef TIMER_BANK_CAPTURE_EN
    , .cap_in(cap_in), .cap_valid(cap_valid), .cap_value(cap_value)
`endif
  );

  int n_pass = 0;
  int n_total = 0;

  // Model: timestamp is (enabled cycles since clear) / DIV; alarms follow the channel rules.
  int m_cnt;
  bit m_tick;
  int m_deadline[4], m_interval[4];
  bit m_periodic[4], m_armed[4], m_irq[4];

  function automatic int m_ts();
    return (m_cnt / 4) % 256;
  endfunction

  function automatic logic [3:0] m_vec(input bit which);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = which ? m_armed[i] : m_irq[i];
    return v;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_tick = 0;
    for (int i = 0; i < 4; i++) begin
      m_deadline[i] = 0; m_interval[i] = 0;
      m_periodic[i] = 0; m_armed[i] = 0; m_irq[i] = 0;
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_total++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
  endtask

  task automatic apply_stimulus(input bit en, input bit clr, input bit we, input int ch,
                                input int ival, input bit per, input bit arm, input logic [3:0] iclr);
    enable = en; clear = clr; cfg_we = we; cfg_ch = 2'(ch);
    cfg_interval = 8'(ival); cfg_periodic = per; cfg_arm = arm; irq_clr = iclr;
  endtask

  // One clock edge of instance W: advance the model, then compare all observable state.
  task automatic step();
    int  ts_now;
    bit  match[4];
    bit  wr;
    @(posedge clk);
    ts_now = m_ts();
    for (int i = 0; i < 4; i++) begin
      wr = cfg_we && (int'(cfg_ch) == i);
      match[i] = m_tick && enable && m_armed[i] && (ts_now == m_deadline[i]) && !wr;
      if (wr) begin
        m_interval[i] = int'(cfg_interval);
        m_periodic[i] = cfg_periodic;
        m_deadline[i] = (ts_now + int'(cfg_interval)) % 256;
        m_armed[i]    = cfg_arm && (cfg_interval != 0);
      end else if (match[i]) begin
        if (m_periodic[i]) m_deadline[i] = (m_deadline[i] + m_interval[i]) % 256;
        else m_armed[i] = 0;
      end
      if (match[i]) m_irq[i] = 1;
      else if (irq_clr[i]) m_irq[i] = 0;
    end
    if (clear) begin
      m_cnt = 0; m_tick = 0;
    end else if (enable) begin
      m_cnt++;
      m_tick = (m_cnt % 4) == 0;
    end else begin
      m_tick = 0;
    end
    #1;
    check_output("timestamp", 32'(ts), 32'(m_ts()));
    check_output("tick", 32'(tick), 32'(m_tick));
    check_output("irq", 32'(irq), 32'(m_vec(0)));
    check_output("armed", 32'(armed), 32'(m_vec(1)));
  endtask

  // Step with enable held until the model is in the tick cycle for timestamp t.
  task automatic run_to(input int t, input int max_steps);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 4'd0);
    for (int k = 0; k < max_steps; k++) begin
      if (m_ts() == t && m_tick) return;
      step();
    end
    n_total++;
    $display("[TB] FAIL run_to timeout: ts=%0d, expected %0d within %0d cycles", m_ts(), t, max_steps);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    model_reset();
    check_output("rst_ts", 32'(ts), 0);
    check_output("rst_tick", 32'(tick), 0);
    check_output("rst_irq", 32'(irq), 0);
    check_output("rst_armed", 32'(armed), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int first_tick, last_tick, n_ticks, frozen;
    reset = 1'b0;
    en_a = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 4'd0);
`ifdef TIMER_BANK_CAPTURE_EN
    cap_in = 4'd0;
`endif
    model_reset();
    #2;
    check_output("rst_ts_a", ts_a, 0);
    check_output("rst_tick_a", 32'(tick_a), 0);
    check_output("rst_irq_a", 32'(irq_a), 0);
    check_output("rst_armed_a", 32'(armed_a), 0);
`ifdef TIMER_BANK_CAPTURE_EN
    check_output("rst_capv_a", 32'(cap_valid_a), 0);
`endif
    pulse_reset();

    // Default timebase: one tick per 1000 enabled clocks.
    en_a = 1'b1;
    first_tick = 0; last_tick = 0; n_ticks = 0;
    for (int c = 1; c <= 5000; c++) begin
      @(posedge clk);
      #1;
      if (tick_a) begin
        n_ticks++;
        if (first_tick == 0) first_tick = c;
        last_tick = c;
      end
    end
    en_a = 1'b0;
    check_output("a_first_tick", first_tick, 1000);
    check_output("a_last_tick", last_tick, 5000);
    check_output("a_tick_count", n_ticks, 5);
    check_output("a_ts_5000", ts_a, 5);
    repeat (10) @(posedge clk);
    #1;
    check_output("a_ts_frozen", ts_a, 5);
    check_output("a_tick_frozen", 32'(tick_a), 0);

    // One-shot channel 0, interval 3 written at timestamp 10.
    apply_stimulus(1, 1, 0, 0, 0, 0, 0, 4'd0);
    step();
    run_to(10, 100);
    apply_stimulus(1, 0, 1, 0, 3, 0, 1, 4'd0);
    step();
    run_to(13, 100);
    step();
    check_output("os_irq0", 32'(irq[0]), 1);
    check_output("os_armed0", 32'(armed[0]), 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 4'b0001);
    step();
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 4'd0);
    repeat (40) step();
    check_output("os_no_reirq", 32'(irq[0]), 0);

    // Periodic channel 1, interval 2 from timestamp 0; clear collides with the match at 4.
    apply_stimulus(1, 1, 0, 0, 0, 0, 0, 4'd0);
    step();
    apply_stimulus(1, 0, 1, 1, 2, 1, 1, 4'd0);
    step();
    run_to(2, 100);
    step();
    check_output("per_irq_at2", 32'(irq[1]), 1);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 4'b0010);
    step();
    check_output("per_irq_cleared", 32'(irq[1]), 0);
    run_to(4, 100);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 4'b0010);
    step();
    check_output("per_match_beats_clr", 32'(irq[1]), 1);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 4'b0010);
    step();
    run_to(6, 100);
    step();
    check_output("per_irq_at6", 32'(irq[1]), 1);
    check_output("per_still_armed", 32'(armed[1]), 1);
    apply_stimulus(1, 0, 1, 1, 0, 1, 1, 4'b0010);
    step();
    check_output("zero_ival_disarms", 32'(armed[1]), 0);

    // Wrap: interval 10 written at timestamp 250 must fire at timestamp 4.
    run_to(250, 2000);
    apply_stimulus(1, 0, 1, 2, 10, 0, 1, 4'd0);
    step();
    run_to(4, 200);
    check_output("wrap_ts", 32'(ts), 4);
    step();
    check_output("wrap_irq2", 32'(irq[2]), 1);

    // Enable low freezes the timebase.
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 4'd0);
    frozen = int'(ts);
    repeat (10) step();
    check_output("freeze_ts", 32'(ts), frozen);

    // Clear zeroes the timebase at the next edge even with enable high.
    repeat (6) begin
      apply_stimulus(1, 0, 0, 0, 0, 0, 0, 4'd0);
      step();
    end
    apply_stimulus(1, 1, 0, 0, 0, 0, 0, 4'd0);
    step();
    check_output("clear_ts", 32'(ts), 0);

    // Reset mid-interval discards the pending alarm on channel 3.
    apply_stimulus(1, 0, 1, 3, 5, 1, 1, 4'd0);
    step();
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 4'd0);
    repeat (9) step();
    pulse_reset();
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 4'd0);
    repeat (30) step();
    check_output("post_rst_no_irq3", 32'(irq[3]), 0);

`ifdef TIMER_BANK_CAPTURE_EN
    apply_stimulus(1, 1, 0, 0, 0, 0, 0, 4'd0);
    step();
    run_to(7, 100);
    cap_in = 4'b0100;
    step();
    step();
    check_output("cap_valid_early", 32'(cap_valid[2]), 0);
    step();
    check_output("cap_valid", 32'(cap_valid[2]), 1);
    check_output("cap_value", 32'(cap_value[16 +: 8]), 7);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 4'b0100);
    step();
    check_output("cap_clr", 32'(cap_valid[2]), 0);
    cap_in = 4'd0;
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 800; k++) begin
      apply_stimulus(($urandom % 8) != 0, ($urandom % 64) == 0, ($urandom % 6) == 0,
                     int'($urandom % 4), int'($urandom % 10), 1'($urandom % 2),
                     ($urandom % 4) != 0, (($urandom % 5) == 0) ? 4'($urandom % 16) : 4'd0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 1000000: integer input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1000: timestamp increment rate in Hz, so one timestamp unit is 1/TICK_HZ s.
REQ-003 SHALL have parameter N_CH, default 4: number of alarm channels, 1..16.
REQ-004 SHALL have parameter CNT_W, default 32: width of timestamp, interval and deadline values.
REQ-005 SHALL have ports: clk in 1, system clock; reset in 1, asynchronous, active-low (asserted at 0).
REQ-006 SHALL have ports: enable in 1, timebase run; clear in 1, synchronous zero of the timebase.
REQ-007 SHALL have ports: timestamp out CNT_W, tick count; tick out 1, one-cycle pulse per increment.
REQ-008 SHALL have ports: cfg_we in 1; cfg_ch in $clog2(N_CH) (min 1); cfg_interval in CNT_W; cfg_periodic in 1; cfg_arm in 1.
REQ-009 SHALL have ports: irq out N_CH, sticky alarm flags; irq_clr in N_CH; armed out N_CH.

Function
REQ-010 SHALL set DIV = CLK_FREQ_HZ/TICK_HZ and raise an elaboration $error if TICK_HZ > CLK_FREQ_HZ or CLK_FREQ_HZ % TICK_HZ != 0.
REQ-011 SHALL count the prescaler 0..DIV-1 while enable=1; at the edge where prescaler==DIV-1: prescaler<=0, timestamp<=timestamp+1, tick<=1; otherwise tick<=0.
REQ-012 SHALL increment timestamp on every enabled cycle when DIV=1.
REQ-013 SHALL hold prescaler and timestamp and drive tick=0 while enable=0.
REQ-014 SHALL, on clear=1, zero prescaler, timestamp and tick at the next edge, regardless of enable; channel state is unaffected.
REQ-015 SHALL wrap timestamp modulo 2^CNT_W with no flag.
REQ-016 SHALL, on cfg_we, update channel cfg_ch at the next edge: interval<=cfg_interval; periodic<=cfg_periodic; deadline<=timestamp+cfg_interval (mod 2^CNT_W); armed<=cfg_arm.
REQ-017 SHALL force armed<=0 when cfg_we carries cfg_interval=0.
REQ-018 SHALL detect a match in any cycle with tick=1, armed=1 and timestamp==deadline; irq goes to 1 at the following edge (1-cycle latency from tick).
REQ-019 SHALL, on a match, clear armed for one-shot channels; for periodic channels it SHALL set deadline<=deadline+interval, keeping armed=1.
REQ-020 SHALL clear irq[i] on irq_clr[i]=1; a match in the same cycle wins and irq stays 1.
REQ-021 SHALL discard a match on a channel that is written by cfg_we in the same cycle; the write wins.
REQ-022 SHALL handle deadline wrap-around by equality compare only; no channel matches while enable=0.

Reset
REQ-023 SHALL, while reset=0, asynchronously drive prescaler=0, timestamp=0, tick=0, irq=0 and armed=0, and zero all intervals and deadlines.
REQ-024 SHALL leave the timebase stopped after reset release until enable=1; reset asserted mid-interval SHALL discard all pending alarms.

Configuration
REQ-025 SHALL, with macro TIMER_BANK_CAPTURE_EN defined, add ports cap_in in N_CH, cap_valid out N_CH and cap_value out N_CH*CNT_W.
REQ-026 SHALL, under TIMER_BANK_CAPTURE_EN, pass each cap_in through a 2-flop synchroniser and rising-edge detector, then latch timestamp into cap_value[i] and set cap_valid[i]; cap_valid is high 3 edges after cap_in rises.
REQ-027 SHALL, under TIMER_BANK_CAPTURE_EN, clear cap_valid[i] on irq_clr[i] with new-capture priority, and let a later edge overwrite cap_value.
REQ-028 SHALL, without TIMER_BANK_CAPTURE_EN, omit the capture ports and logic entirely.

Structure
REQ-029 SHALL place the default parameter constants, the mode enum (ONE_SHOT, PERIODIC) and a DIV-computing function in package timer_bank_pkg.
REQ-030 SHALL implement per-channel deadline, interval, armed, irq and capture state in sub-module timer_channel, generated N_CH times; the prescaler and timestamp stay in timer_bank.

Verification
REQ-031 SHALL cover: CLK_FREQ_HZ=1e6, TICK_HZ=1e3, enable held -> tick every 1000 clk, timestamp=5 after 5000 enabled cycles.
REQ-032 SHALL cover: ch0 one-shot, interval=3, written at timestamp=10 -> irq[0] one edge after the tick that makes timestamp=13, armed[0]=0, no further irq after irq_clr.
REQ-033 SHALL cover: ch1 periodic, interval=2 -> irq[1] after timestamps 2, 4, 6; irq_clr coinciding with the match at 4 leaves irq[1]=1.
REQ-034 SHALL cover: CNT_W=8, timestamp=250, interval=10 -> deadline=4, match after wrap at timestamp=4.
REQ-035 SHALL cover: reset=0 pulse mid-count with enable=1 and clear=1 applied separately -> all outputs 0 immediately (reset) / at next edge (clear); enable=0 freezes timestamp.
REQ-036 SHALL cover, with TIMER_BANK_CAPTURE_EN: cap_in[2] rises while timestamp=7 and is stable -> cap_valid[2]=1 after 3 edges, cap_value[2]=7.
